cdt_block_loader: RTL and testbench

Upstream feeder for the 8x8 inverse-CDT stage. Accepts a byte stream of 64 coefficients per block over a valid/ready handshake and packs each block into a row-addressed 8x64-bit store. Hands completed blocks to the transform stage with a one-cycle start pulse. Two ping-pong banks let the next block load while the transform stage reads the current one.

---
 rtl/cdt_block_loader.sv | 104 ++++++++++
 tb/tb_cdt_block_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdt_block_loader.sv
// Ping-pong block loader feeding the 8x8 inverse-CDT stage: packs 64 coefficient bytes per block
// into one of two 8x64-bit banks. Define CDT_ZIGZAG_EN for JPEG zig-zag input order (raster otherwise).
//
// state   | meaning
// R_IDLE  | no block presented; waits for a complete bank
// R_PULSE | one-cycle cdt_start for the read bank
// R_BUSY  | transform stage reading rd_bank; waits for cdt_done
module cdt_block_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  rd_row,
   output logic [63:0] rd_data,
   output logic        cdt_start,
   input  logic        cdt_done,
   output logic [1:0]  full_cnt
);

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_PULSE = 2'd1,
      R_BUSY  = 2'd2
   } rd_state_t;

   rd_state_t   state, state_nxt;
   logic [63:0] mem [2][8];
   logic [5:0]  k;
   logic [5:0]  pos;
   logic        wr_bank, rd_bank;
   logic        accept, blk_last, done_ev;

`ifdef CDT_ZIGZAG_EN
   localparam logic [0:63][5:0] ZZ = {
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };
   assign pos = ZZ[k];
`else
   assign pos = k;
`endif

   // Ready depends only on registered occupancy, never on in_valid.
   assign in_ready = (full_cnt != 2'd2);
   assign accept   = in_valid & in_ready;
   assign blk_last = accept & (k == 6'd63);
   assign done_ev  = cdt_done & (state == R_BUSY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k        <= '0;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         full_cnt <= '0;
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
               mem[b][r] <= '0;
      end else begin
         if (accept) begin
            mem[wr_bank][pos[5:3]][{pos[2:0], 3'b000} +: 8] <= in_data;
            k <= k + 6'd1;
         end
         if (blk_last)
            wr_bank <= ~wr_bank;
         if (done_ev)
            rd_bank <= ~rd_bank;
         // A completion and a release on the same edge cancel out.
         if (blk_last && !done_ev)
            full_cnt <= full_cnt + 2'd1;
         else if (!blk_last && done_ev)
            full_cnt <= full_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= R_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         R_IDLE:  if (full_cnt != 2'd0) state_nxt = R_PULSE;
         R_PULSE: state_nxt = R_BUSY;
         R_BUSY:  if (cdt_done) state_nxt = R_IDLE;
         default: state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      cdt_start = (state == R_PULSE);
      rd_data   = mem[rd_bank][rd_row];
   end

endmodule

// File: tb/tb_cdt_block_loader.sv
// Scoreboard bench for cdt_block_loader: a byte-level reference model queues each completed block,
// and a monitor reads all eight rows back whenever cdt_start is presented.
module tb_cdt_block_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  rd_row = 3'd0;
   logic [63:0] rd_data;
   logic        cdt_start;
   logic        cdt_done = 1'b0;
   logic [1:0]  full_cnt;

   int checks = 0;
   int failures = 0;

   logic [511:0] exp_q[$];
   logic [511:0] cur_blk;
   int  m_k;
   int  m_full;
   bit  m_busy;
   bit  m_started;
   int  pos_of[64];
   int  blk_no = 0;

   cdt_block_loader dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .rd_row   (rd_row),
      .rd_data  (rd_data),
      .cdt_start(cdt_start),
      .cdt_done (cdt_done),
      .full_cnt (full_cnt)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Input order walks anti-diagonals, alternating direction, when zig-zag is enabled.
   function automatic void build_order();
`ifdef CDT_ZIGZAG_EN
      int idx = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin pos_of[idx] = 8 * r + (s - r); idx++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin pos_of[idx] = 8 * r + (s - r); idx++; end
         end
      end
`else
      for (int i = 0; i < 64; i++) pos_of[i] = i;
`endif
   endfunction

   task automatic model_reset();
      m_k = 0;
      m_full = 0;
      m_busy = 0;
      m_started = 0;
      cur_blk = '0;
      exp_q.delete();
   endtask

   // One clock: drive at negedge, update the model at posedge, sample at the next negedge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic dn);
      bit acc, comp, dn_eff;
      in_valid = v;
      in_data  = d;
      cdt_done = dn;
      chk("in_ready", 64'(in_ready), 64'(m_full != 2));
      @(posedge clk);
      acc    = v && (m_full != 2);
      comp   = 0;
      dn_eff = dn && m_busy;
      if (acc) begin
         cur_blk[pos_of[m_k] * 8 +: 8] = d;
         if (m_k == 63) begin
            comp = 1;
            exp_q.push_back(cur_blk);
            m_k = 0;
         end else begin
            m_k++;
         end
      end
      m_full = m_full + int'(comp) - int'(dn_eff);
      if (dn_eff) m_busy = 0;
      if (m_started) begin m_busy = 1; m_started = 0; end
      @(negedge clk);
      in_valid = 1'b0;
      cdt_done = 1'b0;
      chk("full_cnt", 64'(full_cnt), 64'(m_full));
      if (cdt_start) m_started = 1;
   endtask

   initial begin : monitor
      logic [511:0] blk;
      forever begin
         @(negedge clk);
         if (rst && cdt_start) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL start_no_block: cdt_start=1 with 0 completed blocks expected");
            end else begin
               blk = exp_q.pop_front();
               for (int r = 0; r < 8; r++) begin
                  rd_row = 3'(r);
                  #1;
                  chk($sformatf("blk%0d_row%0d", blk_no, r), rd_data, blk[64 * r +: 64]);
               end
               if (blk_no == 0) begin
`ifdef CDT_ZIGZAG_EN
                  rd_row = 3'd0;
                  #1;
                  chk("zz_row0_const", rd_data, 64'h1C1B0F0E06050100);
                  rd_row = 3'd1;
                  #1;
                  chk("zz_row1_lane0", 64'(rd_data[7:0]), 64'h02);
`else
                  rd_row = 3'd3;
                  #1;
                  chk("raster_row3_const", rd_data, 64'h1F1E1D1C1B1A1918);
`endif
               end
               blk_no++;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      build_order();
      model_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_cdt_start", 64'(cdt_start), 64'd0);
      chk("rst_full_cnt", 64'(full_cnt), 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Raster fill 0x00..0x3F, pulse latency, done during R_PULSE ignored.
      for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0);
      chk("t1_start_early", 64'(cdt_start), 64'd0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("t1_start_lat", 64'(cdt_start), 64'd1);
      cycle(1'b0, 8'h00, 1'b1);
      chk("t1_single_pulse", 64'(cdt_start), 64'd0);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      // Spurious done while idle and empty.
      cycle(1'b0, 8'h00, 1'b1);
      chk("t4_idle_start", 64'(cdt_start), 64'd0);
      cycle(1'b0, 8'h00, 1'b1);
      chk("t4_idle_start2", 64'(cdt_start), 64'd0);

      // Back-to-back: 128 bytes, done withheld, 129th byte refused.
      for (int i = 0; i < 128; i++) cycle(1'b1, 8'($urandom), 1'b0);
      chk("t2_full_two", 64'(full_cnt), 64'd2);
      cycle(1'b1, 8'hAA, 1'b0);
      chk("t2_ready_low", 64'(in_ready), 64'd0);
      cycle(1'b0, 8'h00, 1'b1);
      chk("t2_ready_back", 64'(in_ready), 64'd1);
      chk("t2_start_early", 64'(cdt_start), 64'd0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("t2_restart_lat", 64'(cdt_start), 64'd1);
      cycle(1'b0, 8'h00, 1'b0);

      // Last byte of a block on the same edge as cdt_done.
      for (int i = 0; i < 63; i++) cycle(1'b1, 8'($urandom), 1'b0);
      cycle(1'b1, 8'($urandom), 1'b1);
      chk("t3_full_same", 64'(full_cnt), 64'd1);
      chk("t3_start_early", 64'(cdt_start), 64'd0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("t3_start", 64'(cdt_start), 64'd1);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);

      // Reset after 20 bytes of a block.
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 1'b0);
      rst = 1'b0;
      #1;
      chk("t5_in_ready", 64'(in_ready), 64'd1);
      chk("t5_cdt_start", 64'(cdt_start), 64'd0);
      chk("t5_full_cnt", 64'(full_cnt), 64'd0);
      chk("t5_rd_data", rd_data, 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 64; i++) cycle(1'b1, 8'($urandom), 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("t5_start", 64'(cdt_start), 64'd1);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);

      // Random traffic with random release timing.
      for (int i = 0; i < 1500; i++)
         cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
               1'(m_busy && ($urandom_range(0, 5) == 0)));

      n = 0;
      while ((m_full > 0 || m_busy || m_started) && n < 2000) begin
         cycle(1'b0, 8'h00, 1'(m_busy));
         n++;
      end
      chk("drain_bound", 64'(n < 2000), 64'd1);
      chk("drain_queue", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
